// File: rtl/mem_test_master.sv
// Memory test master: fills a word range with seed+i over Avalon-MM, reads it back
// with fixed 1-cycle read latency, and reports mismatch count and first failing address.
module mem_test_master #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 12000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [31:0]       seed,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic [31:0]       m_readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              range_err,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [1:0]        mode_r;
    logic [ADDR_W-1:0] base_r, n_r, idx_r, idx_s, idx_inc_s;
    logic [31:0]       seed_r;
    logic              cmp_pend_r;
    logic [31:0]       cmp_exp_r;
    logic [ADDR_W-1:0] cmp_addr_r;
    logic [15:0]       err_count_r, err_next_s;
    logic [ADDR_W-1:0] first_err_r, first_err_s;
    logic              range_err_r, range_err_s;
    logic              pass_r, pass_s, done_r, done_s, busy_r, busy_s;
    logic              cs_r, cs_s, wr_r, wr_s, clken_r;
    logic [3:0]        be_r, be_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [31:0]       wdata_r, wdata_s;
    logic [ADDR_W:0]   span_end_s;
    logic              over_s, last_s, mism_s, accept_s;

    function automatic logic [31:0] pattern_word(input logic [31:0] s, input logic [ADDR_W-1:0] i);
        return s + 32'(i);
    endfunction

    assign m_address      = addr_r;
    assign m_byteenable   = be_r;
    assign m_chipselect   = cs_r;
    assign m_write        = wr_r;
    assign m_writedata    = wdata_r;
    assign m_clken        = clken_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign range_err      = range_err_r;
    assign err_count      = err_count_r;
    assign first_err_addr = first_err_r;

    // Read-back comparison of the word returned one cycle after each read
    always_comb begin
        mism_s = cmp_pend_r && (m_readdata != cmp_exp_r);
        if (mism_s && (err_count_r != 16'hFFFF)) begin
            err_next_s = err_count_r + 16'd1;
        end else begin
            err_next_s = err_count_r;
        end
        if (mism_s && (err_count_r == 16'd0)) begin
            first_err_s = cmp_addr_r;
        end else begin
            first_err_s = first_err_r;
        end
    end

    // Next state and next registered bus/status outputs
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        cs_s        = 1'b0;
        wr_s        = 1'b0;
        be_s        = 4'h0;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        done_s      = 1'b0;
        busy_s      = 1'b1;
        pass_s      = pass_r;
        range_err_s = range_err_r;
        accept_s    = 1'b0;
        span_end_s  = {1'b0, base_addr} + {1'b0, word_count};
        over_s      = span_end_s > (ADDR_W+1)'(DEPTH);
        last_s      = (idx_r == (n_r - ADDR_W'(1)));
        idx_inc_s   = idx_r + ADDR_W'(1);
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (start) begin
                    accept_s    = 1'b1;
                    busy_s      = 1'b1;
                    pass_s      = 1'b0;
                    range_err_s = over_s;
                    if (over_s || (word_count == {ADDR_W{1'b0}})) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                        pass_s  = !over_s;
                    end else if (mode == 2'b10) begin
                        state_s = RD;
                        idx_s   = {ADDR_W{1'b0}};
                        cs_s    = 1'b1;
                        be_s    = 4'hF;
                        addr_s  = base_addr;
                    end else begin
                        state_s = WR;
                        idx_s   = {ADDR_W{1'b0}};
                        cs_s    = 1'b1;
                        wr_s    = 1'b1;
                        be_s    = 4'hF;
                        addr_s  = base_addr;
                        wdata_s = seed;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WR: begin
                if (last_s) begin
                    if (mode_r == 2'b01) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                        pass_s  = (err_next_s == 16'd0) && !range_err_r;
                    end else begin
                        state_s = RD;
                        idx_s   = {ADDR_W{1'b0}};
                        cs_s    = 1'b1;
                        be_s    = 4'hF;
                        addr_s  = base_r;
                    end
                end else begin
                    idx_s   = idx_inc_s;
                    cs_s    = 1'b1;
                    wr_s    = 1'b1;
                    be_s    = 4'hF;
                    addr_s  = base_r + idx_inc_s;
                    wdata_s = pattern_word(seed_r, idx_inc_s);
                end
            end
            RD: begin
                if (last_s) begin
                    state_s = DRAIN;
                end else begin
                    idx_s  = idx_inc_s;
                    cs_s   = 1'b1;
                    be_s   = 4'hF;
                    addr_s = base_r + idx_inc_s;
                end
            end
            DRAIN: begin
                // the final read's data is judged this cycle, so pass must see err_next_s
                state_s = DONE;
                done_s  = 1'b1;
                pass_s  = (err_next_s == 16'd0) && !range_err_r;
            end
            DONE: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, run parameters, compare pipeline and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= {ADDR_W{1'b0}};
            mode_r      <= 2'b00;
            base_r      <= {ADDR_W{1'b0}};
            n_r         <= {ADDR_W{1'b0}};
            seed_r      <= 32'h0;
            cmp_pend_r  <= 1'b0;
            cmp_exp_r   <= 32'h0;
            cmp_addr_r  <= {ADDR_W{1'b0}};
            err_count_r <= 16'd0;
            first_err_r <= {ADDR_W{1'b0}};
            range_err_r <= 1'b0;
            pass_r      <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            cs_r        <= 1'b0;
            wr_r        <= 1'b0;
            be_r        <= 4'h0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= 32'h0;
            clken_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            if (accept_s) begin
                mode_r <= mode;
                base_r <= base_addr;
                n_r    <= word_count;
                seed_r <= seed;
            end
            cmp_pend_r  <= (state_r == RD);
            cmp_exp_r   <= pattern_word(seed_r, idx_r);
            cmp_addr_r  <= base_r + idx_r;
            err_count_r <= accept_s ? 16'd0 : err_next_s;
            first_err_r <= accept_s ? {ADDR_W{1'b0}} : first_err_s;
            range_err_r <= range_err_s;
            pass_r      <= pass_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
            cs_r        <= cs_s;
            wr_r        <= wr_s;
            be_r        <= be_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            clken_r     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_test_master.sv
// Bench for mem_test_master: ideal 1-cycle-latency memory with optional corruption,
// directed and randomized runs checked against a run-level reference model.
module tb_mem_test_master;

    localparam int AW  = 14;
    localparam int DEP = 12000;
    localparam int SAW = 17;
    localparam int SDEP = 65545;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr, word_count;
    logic [31:0]   seed;
    logic [AW-1:0] m_address;
    logic [3:0]    m_byteenable;
    logic          m_chipselect, m_write, m_clken;
    logic [31:0]   m_writedata, m_readdata;
    logic          busy, done, pass, range_err;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;

    logic           sat_start;
    logic [1:0]     sat_mode;
    logic [SAW-1:0] sat_base, sat_count, sat_address, sat_first_err;
    logic [31:0]    sat_seed, sat_writedata, sat_readdata;
    logic [3:0]     sat_byteenable;
    logic           sat_chipselect, sat_write, sat_clken;
    logic           sat_busy, sat_done, sat_pass, sat_range_err;
    logic [15:0]    sat_err_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0]   mem [0:DEP-1];
    logic [31:0]   ref_mem [0:DEP-1];
    logic          mem_clear;
    logic          corrupt_en;
    logic [AW-1:0] corrupt_addr;
    logic [49:0]   wr_log[$];
    logic [AW-1:0] rd_log[$];

    always #5 clk = ~clk;

    mem_test_master #(.ADDR_W(AW), .DEPTH(DEP)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .word_count(word_count), .seed(seed),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_clken(m_clken), .m_readdata(m_readdata),
        .busy(busy), .done(done), .pass(pass), .range_err(range_err),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    mem_test_master #(.ADDR_W(SAW), .DEPTH(SDEP)) u_sat (
        .clk(clk), .reset(reset), .start(sat_start), .mode(sat_mode),
        .base_addr(sat_base), .word_count(sat_count), .seed(sat_seed),
        .m_address(sat_address), .m_byteenable(sat_byteenable),
        .m_chipselect(sat_chipselect), .m_write(sat_write),
        .m_writedata(sat_writedata), .m_clken(sat_clken), .m_readdata(sat_readdata),
        .busy(sat_busy), .done(sat_done), .pass(sat_pass), .range_err(sat_range_err),
        .err_count(sat_err_count), .first_err_addr(sat_first_err)
    );

    // Memory with one-cycle read latency; a selected word reads back with bit 0 flipped
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEP; i++) mem[i] <= 32'h0;
        end else if (m_chipselect && m_write) begin
            mem[m_address] <= m_writedata;
        end else if (m_chipselect) begin
            m_readdata <= mem[m_address] ^ ((corrupt_en && m_address == corrupt_addr) ? 32'h1 : 32'h0);
        end
    end

    // Bus access log
    always @(posedge clk) begin
        if (m_chipselect) begin
            if (m_write) wr_log.push_back({m_address, m_writedata, m_byteenable});
            else         rd_log.push_back(m_address);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] md, input logic [AW-1:0] b,
                       input logic [AW-1:0] n, input logic [31:0] sd, input bit poke);
        int          exp_lat, errs, cyc, wb, rb, limit;
        bit          rerr, fill, vfy, exp_pass;
        logic [AW-1:0] first, a;
        logic [31:0] obs;
        logic [49:0] exp_w[$];
        logic [AW-1:0] exp_r[$];
        rerr = (int'(b) + int'(n)) > DEP;
        fill = !rerr && n != 0 && md != 2'b10;
        vfy  = !rerr && n != 0 && md != 2'b01;
        errs = 0;
        first = '0;
        if (fill) begin
            for (int i = 0; i < int'(n); i++) begin
                a = b + AW'(i);
                exp_w.push_back({a, sd + 32'(i), 4'hF});
                ref_mem[a] = sd + 32'(i);
            end
        end
        if (vfy) begin
            for (int i = 0; i < int'(n); i++) begin
                a = b + AW'(i);
                exp_r.push_back(a);
                obs = ref_mem[a] ^ ((corrupt_en && corrupt_addr == a) ? 32'h1 : 32'h0);
                if (obs != sd + 32'(i)) begin
                    if (errs == 0) first = a;
                    errs++;
                end
            end
        end
        if (rerr || n == 0)  exp_lat = 1;
        else if (md == 2'b01) exp_lat = int'(n) + 1;
        else if (md == 2'b10) exp_lat = int'(n) + 2;
        else                  exp_lat = 2 * int'(n) + 2;
        exp_pass = !rerr && errs == 0;
        limit = 2 * int'(n) + 10;

        @(negedge clk);
        start = 1'b1; mode = md; base_addr = b; word_count = n; seed = sd;
        wb = wr_log.size();
        rb = rd_log.size();
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check({tag, ".busy1"}, busy, 1'b1);
        while (done !== 1'b1 && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
            start = poke && cyc == 2;
            if (start) begin mode = 2'b01; word_count = 14'd1; end
        end
        start = 1'b0;
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".latency"}, cyc, exp_lat);
        check({tag, ".pass"}, pass, exp_pass);
        check({tag, ".range_err"}, range_err, rerr);
        check({tag, ".err_count"}, err_count, errs);
        check({tag, ".first_err"}, first_err_addr, first);
        @(posedge clk); #1;
        check({tag, ".done_drop"}, done, 1'b0);
        check({tag, ".idle"}, busy, 1'b0);
        check({tag, ".pass_hold"}, pass, exp_pass);
        check({tag, ".n_writes"}, wr_log.size() - wb, exp_w.size());
        check({tag, ".n_reads"}, rd_log.size() - rb, exp_r.size());
        for (int i = 0; i < exp_w.size() && wb + i < wr_log.size(); i++)
            check({tag, ".write"}, wr_log[wb + i], exp_w[i]);
        for (int i = 0; i < exp_r.size() && rb + i < rd_log.size(); i++)
            check({tag, ".read"}, rd_log[rb + i], exp_r[i]);
    endtask

    initial begin
        logic [1:0]    md;
        logic [AW-1:0] b, n;
        int            cyc, lb;
        bit            done_seen;

        reset = 1'b1; start = 1'b0; mode = 2'b00; base_addr = '0; word_count = '0; seed = 32'h0;
        mem_clear = 1'b1; corrupt_en = 1'b0; corrupt_addr = '0;
        sat_start = 1'b0; sat_mode = 2'b10; sat_base = 17'd5; sat_count = 17'd65540;
        sat_seed = 32'h0; sat_readdata = 32'hFFFF_FFFF;
        for (int i = 0; i < DEP; i++) ref_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.pass", pass, 1'b0);
        check("rst.range_err", range_err, 1'b0);
        check("rst.err_count", err_count, 16'd0);
        check("rst.first_err", first_err_addr, 14'd0);
        check("rst.cs", m_chipselect, 1'b0);
        check("rst.write", m_write, 1'b0);
        check("rst.addr", m_address, 14'd0);
        check("rst.wdata", m_writedata, 32'h0);
        check("rst.be", m_byteenable, 4'h0);
        check("rst.clken", m_clken, 1'b0);
        reset = 1'b0; mem_clear = 1'b0;
        @(posedge clk); #1;
        check("clken_on", m_clken, 1'b1);

        run("fv_basic", 2'b00, 14'h0010, 14'd4, 32'hA5A5_0000, 1'b0);
        corrupt_en = 1'b1; corrupt_addr = 14'h0012;
        run("fv_corrupt", 2'b00, 14'h0010, 14'd4, 32'hA5A5_0000, 1'b0);
        corrupt_en = 1'b0;
        run("n_zero", 2'b00, 14'h0020, 14'd0, 32'h1234_5678, 1'b0);
        run("range_over", 2'b00, 14'd11998, 14'd3, 32'h1111_0000, 1'b0);
        run("range_edge", 2'b11, 14'd11997, 14'd3, 32'h2222_0000, 1'b0);
        run("fill_only", 2'b01, 14'h0100, 14'd2, 32'hCAFE_0000, 1'b0);
        run("verify_only", 2'b10, 14'h0100, 14'd2, 32'hCAFE_0000, 1'b0);
        run("start_busy", 2'b00, 14'h0200, 14'd5, 32'h0BAD_F00D, 1'b1);

        for (int k = 0; k < 14; k++) begin
            md = 2'($urandom_range(0, 3));
            n  = AW'($urandom_range(0, 12));
            b  = (k % 3 == 0) ? AW'($urandom_range(11988, 11999)) : AW'($urandom_range(0, 400));
            corrupt_en   = 1'($urandom_range(0, 1));
            corrupt_addr = b + AW'($urandom_range(0, 12));
            run("rand", md, b, n, $urandom, 1'b0);
        end
        corrupt_en = 1'b0;

        @(negedge clk);
        start = 1'b1; mode = 2'b00; base_addr = 14'h0300; word_count = 14'd6; seed = 32'h7777_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid.write_i2", m_write, 1'b1);
        check("mid.addr_i2", m_address, 14'h0302);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid.write_off", m_write, 1'b0);
        check("mid.cs_off", m_chipselect, 1'b0);
        check("mid.busy_off", busy, 1'b0);
        reset = 1'b0;
        lb = wr_log.size() + rd_log.size();
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen = 1'b1;
        end
        check("mid.no_done", done_seen, 1'b0);
        check("mid.no_bus", wr_log.size() + rd_log.size() - lb, 0);

        @(negedge clk);
        sat_start = 1'b1;
        @(posedge clk); #1;
        sat_start = 1'b0;
        cyc = 1;
        while (sat_done !== 1'b1 && cyc < 65600) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("sat.done", sat_done, 1'b1);
        check("sat.latency", cyc, 65542);
        check("sat.err_count", sat_err_count, 16'hFFFF);
        check("sat.first_err", sat_first_err, 17'd5);
        check("sat.pass", sat_pass, 1'b0);
        check("sat.range_err", sat_range_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
